// File: rtl/stream_fifo_reader_if.sv
// Signal bundle between a raw fixed-latency FIFO read port and a valid/ready
// stream consumer. The reader drives through 'master'; the environment uses 'slave'.
interface stream_fifo_reader_if #(
   parameter int Width = 8
);
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [Width-1:0] fifo_rd_data;
   logic             dout_valid;
   logic             dout_ready;
   logic [Width-1:0] dout_data;

   modport master (
      input  fifo_empty, fifo_rd_data, dout_ready,
      output fifo_rd_en, dout_valid, dout_data
   );

   modport slave (
      output fifo_empty, fifo_rd_data, dout_ready,
      input  fifo_rd_en, dout_valid, dout_data
   );
endinterface

// File: rtl/stream_fifo_reader.sv
// Read-side adapter: issues FIFO reads ahead into a small circular buffer so a
// fixed-latency rd_en/rd_data port becomes a bubble-free valid/ready stream.
module stream_fifo_reader #(
   parameter int Width       = 8,
   parameter int ReadLatency = 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   stream_fifo_reader_if.master bus
);
   localparam int BufDepth = ReadLatency + 2;
   localparam int CntW     = $clog2(BufDepth + 1);
   localparam int PtrW     = $clog2(BufDepth);
   localparam logic [CntW-1:0] DepthC   = CntW'(BufDepth);
   localparam logic [PtrW-1:0] LastPtrC = PtrW'(BufDepth - 1);

   logic [ReadLatency-1:0] vld_pipe_q, vld_pipe_d;
   logic [CntW-1:0]        outst_q, outst_d;
   logic [CntW-1:0]        bufd_q, bufd_d;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [Width-1:0]       mem_q [BufDepth];
   logic                   rd_en, arrive, valid, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtrC) ? '0 : p + 1'b1;
   endfunction

   // Every issued read holds a buffer slot until popped, so arrivals never overflow.
   assign rd_en  = ~rst_i & ~bus.fifo_empty & (outst_q < DepthC);
   assign arrive = vld_pipe_q[ReadLatency-1];
   assign valid  = (bufd_q != '0);
   assign pop    = valid & bus.dout_ready;

   always_comb begin
      vld_pipe_d = (vld_pipe_q << 1) | ReadLatency'(rd_en);
      outst_d    = outst_q + CntW'(rd_en) - CntW'(pop);
      bufd_d     = bufd_q + CntW'(arrive) - CntW'(pop);
      wr_ptr_d   = arrive ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe_q <= '0;
         outst_q    <= '0;
         bufd_q     <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         outst_q    <= outst_d;
         bufd_q     <= bufd_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (arrive) mem_q[wr_ptr_q] <= bus.fifo_rd_data;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert (outst_q <= DepthC);
         assert (bufd_q <= outst_q);
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.dout_valid = valid;
   assign bus.dout_data  = mem_q[rd_ptr_q];
endmodule
